instruction_encoder: RTL and testbench

Streaming RV32I instruction encoder and instruction-memory loader: the inverse of the immediate decode path in the datapath. The block accepts field-level instruction descriptors over a valid/ready handshake, range-checks each immediate, packs the descriptor into a 32-bit word, and writes the words to consecutive instruction-memory addresses. It is used by boot and test infrastructure to fill instruction memory before the core is released from reset.

---
 rtl/instruction_encoder_if.sv | 31 +++
 rtl/instruction_encoder.sv | 92 +++++++++
 tb/tb_instruction_encoder.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/instruction_encoder_if.sv
// instruction_encoder_if: descriptor handshake and memory write bus of the encoder
interface instruction_encoder_if #(parameter int ADDR_W = 8);
  logic              Start;
  logic              InValid;
  logic              InReady;
  logic              Last;
  logic [2:0]        Format;
  logic [6:0]        Opcode;
  logic [2:0]        Funct3;
  logic [6:0]        Funct7;
  logic [4:0]        Rd;
  logic [4:0]        Rs1;
  logic [4:0]        Rs2;
  logic [31:0]       Imm;
  logic              MemWrite;
  logic [ADDR_W-1:0] MemAddr;
  logic [31:0]       MemData;
  logic              MemReady;
  logic [ADDR_W:0]   Count;
  logic              Done;
  logic              Error;
  logic [1:0]        ErrCode;
  modport master (
    output Start, InValid, Last, Format, Opcode, Funct3, Funct7, Rd, Rs1, Rs2, Imm, MemReady,
    input  InReady, MemWrite, MemAddr, MemData, Count, Done, Error, ErrCode
  );
  modport slave (
    input  Start, InValid, Last, Format, Opcode, Funct3, Funct7, Rd, Rs1, Rs2, Imm, MemReady,
    output InReady, MemWrite, MemAddr, MemData, Count, Done, Error, ErrCode
  );
endinterface

// File: rtl/instruction_encoder.sv
// instruction_encoder: packs RV32I field descriptors into words and streams them into instruction memory
module instruction_encoder #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input logic               clk,
  input logic               reset,
  instruction_encoder_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RUN, WRITE, DONE, ERROR} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       word_q, word_d;
  logic              last_q, last_d;
  logic [1:0]        code_q, code_d;
  logic [31:0]       imm, enc;
  logic [2:0]        fmt;
  logic              fmt_bad, mis, rng_ok, at_end;
  assign bus.InReady  = state_q == RUN;
  assign bus.MemWrite = state_q == WRITE;
  assign bus.MemAddr  = addr_q;
  assign bus.MemData  = word_q;
  assign bus.Count    = count_q;
  assign bus.Done     = state_q == DONE;
  assign bus.Error    = state_q == ERROR;
  assign bus.ErrCode  = code_q;
  // immediate checks and word packing for the presented descriptor
  always_comb begin
    imm     = bus.Imm;
    fmt     = bus.Format;
    fmt_bad = fmt > 3'd5;
    mis     = ((fmt == 3'd2 || fmt == 3'd3) && imm[0]) || (fmt == 3'd4 && |imm[11:0]);
    rng_ok  = (fmt == 3'd0 || fmt == 3'd1) ? (&imm[31:11] || ~|imm[31:11]) :
              fmt == 3'd2 ? (&imm[31:12] || ~|imm[31:12]) :
              fmt == 3'd3 ? (&imm[31:20] || ~|imm[31:20]) : 1'b1;
    enc = fmt == 3'd0 ? {imm[11:0], bus.Rs1, bus.Funct3, bus.Rd, bus.Opcode} :
          fmt == 3'd1 ? {imm[11:5], bus.Rs2, bus.Rs1, bus.Funct3, imm[4:0], bus.Opcode} :
          fmt == 3'd2 ? {imm[12], imm[10:5], bus.Rs2, bus.Rs1, bus.Funct3, imm[4:1], imm[11], bus.Opcode} :
          fmt == 3'd3 ? {imm[20], imm[10:1], imm[11], imm[19:12], bus.Rd, bus.Opcode} :
          fmt == 3'd4 ? {imm[31:12], bus.Rd, bus.Opcode} :
                        {bus.Funct7, bus.Rs2, bus.Rs1, bus.Funct3, bus.Rd, bus.Opcode};
  end
  // session sequencing: accept, write with backpressure, finish or fault
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    word_d  = word_q;
    last_d  = last_q;
    code_d  = code_q;
    at_end  = addr_q == ADDR_W'(DEPTH - 1);
    case (state_q)
      RUN: if (bus.InValid) begin
        state_d = (fmt_bad || mis || !rng_ok) ? ERROR : WRITE;
        code_d  = fmt_bad ? 2'b00 : mis ? 2'b10 : !rng_ok ? 2'b01 : code_q;
        word_d  = (fmt_bad || mis || !rng_ok) ? word_q : enc;
        last_d  = bus.Last;
      end
      WRITE: if (bus.MemReady) begin
        addr_d  = addr_q + 1'b1;
        count_d = count_q + 1'b1;
        state_d = last_q ? DONE : at_end ? ERROR : RUN;
        code_d  = (!last_q && at_end) ? 2'b11 : code_q;
      end
      default: if (bus.Start) begin
        state_d = RUN;
        addr_d  = '0;
        count_d = '0;
        code_d  = 2'b00;
      end
    endcase
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      word_q  <= word_d;
      last_q  <= last_d;
      code_q  <= code_d;
    end
  end
endmodule

// File: tb/tb_instruction_encoder.sv
// tb_instruction_encoder: directed checks of encoding, range/alignment faults, backpressure, overflow and reset
module tb_instruction_encoder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n = 0;
  int   fails = 0;
  instruction_encoder_if #(.ADDR_W(8)) a();
  instruction_encoder_if #(.ADDR_W(2)) b();
  instruction_encoder #(.DEPTH(256), .ADDR_W(8)) dut_a (.clk(clk), .reset(reset), .bus(a));
  instruction_encoder #(.DEPTH(4), .ADDR_W(2)) dut_b (.clk(clk), .reset(reset), .bus(b));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic desc(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                      input logic last);
    a.Format = f; a.Opcode = op; a.Funct3 = f3; a.Funct7 = f7;
    a.Rd = rd; a.Rs1 = rs1; a.Rs2 = rs2; a.Imm = imm; a.Last = last;
  endtask
  task automatic send;
    logic ok;
    ok = 1'b0;
    a.InValid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (a.InReady) ok = 1'b1;
      tick;
    end
    a.InValid = 1'b0;
    chk("accept", 32'(ok), 32'd1);
  endtask
  task automatic start_a;
    a.Start = 1'b1;
    tick;
    a.Start = 1'b0;
  endtask
  task automatic reset_vals(input string tag);
    chk({tag, " InReady"}, 32'(a.InReady), 0);
    chk({tag, " MemWrite"}, 32'(a.MemWrite), 0);
    chk({tag, " MemAddr"}, 32'(a.MemAddr), 0);
    chk({tag, " MemData"}, a.MemData, 0);
    chk({tag, " Count"}, 32'(a.Count), 0);
    chk({tag, " Done"}, 32'(a.Done), 0);
    chk({tag, " Error"}, 32'(a.Error), 0);
    chk({tag, " ErrCode"}, 32'(a.ErrCode), 0);
  endtask
  initial begin
    a.Start = 0; a.InValid = 0; a.MemReady = 1;
    desc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    b.Start = 0; b.InValid = 0; b.MemReady = 1; b.Last = 0; b.Format = 0; b.Opcode = 7'h13;
    b.Funct3 = 0; b.Funct7 = 0; b.Rd = 0; b.Rs1 = 0; b.Rs2 = 0; b.Imm = 0;
    tick; tick;
    reset_vals("rst");
    reset = 1'b0;
    tick;
    reset_vals("idle");
    start_a;
    chk("run InReady", 32'(a.InReady), 1);
    desc(0, 7'h13, 0, 0, 1, 0, 0, 5, 1);
    send;
    chk("addi MemWrite", 32'(a.MemWrite), 1);
    chk("addi MemAddr", 32'(a.MemAddr), 0);
    chk("addi MemData", a.MemData, 32'h00500093);
    chk("addi InReady", 32'(a.InReady), 0);
    tick;
    chk("addi Count", 32'(a.Count), 1);
    chk("addi Done", 32'(a.Done), 1);
    chk("addi MemWrite off", 32'(a.MemWrite), 0);
    start_a;
    chk("restart Count", 32'(a.Count), 0);
    chk("restart Done", 32'(a.Done), 0);
    desc(1, 7'h23, 3'd2, 0, 0, 1, 2, 8, 0);
    send;
    chk("sw MemAddr", 32'(a.MemAddr), 0);
    chk("sw MemData", a.MemData, 32'h0020A423);
    tick;
    desc(2, 7'h63, 3'd0, 0, 0, 1, 2, -32'sd4, 0);
    send;
    chk("beq MemAddr", 32'(a.MemAddr), 1);
    chk("beq MemData", a.MemData, 32'hFE208EE3);
    tick;
    desc(3, 7'h6F, 0, 0, 1, 0, 0, 2048, 1);
    send;
    chk("jal MemAddr", 32'(a.MemAddr), 2);
    chk("jal MemData", a.MemData, 32'h001000EF);
    tick;
    chk("seq Count", 32'(a.Count), 3);
    chk("seq Done", 32'(a.Done), 1);
    start_a;
    desc(0, 7'h13, 0, 0, 1, 0, 0, 2048, 1);
    send;
    chk("range Error", 32'(a.Error), 1);
    chk("range ErrCode", 32'(a.ErrCode), 1);
    chk("range MemWrite", 32'(a.MemWrite), 0);
    tick;
    chk("range MemWrite later", 32'(a.MemWrite), 0);
    chk("range Count", 32'(a.Count), 0);
    start_a;
    chk("restart Error", 32'(a.Error), 0);
    desc(2, 7'h63, 0, 0, 0, 1, 2, 3, 1);
    send;
    chk("misalign ErrCode", 32'(a.ErrCode), 2);
    chk("misalign Error", 32'(a.Error), 1);
    start_a;
    desc(7, 7'h13, 0, 0, 1, 0, 0, 0, 1);
    send;
    chk("fmt Error", 32'(a.Error), 1);
    chk("fmt ErrCode", 32'(a.ErrCode), 0);
    start_a;
    desc(4, 7'h37, 0, 0, 5, 0, 0, 32'h12345001, 1);
    send;
    chk("lui misalign ErrCode", 32'(a.ErrCode), 2);
    start_a;
    desc(4, 7'h37, 0, 0, 5, 0, 0, 32'h12345000, 1);
    send;
    chk("lui MemData", a.MemData, 32'h123452B7);
    tick;
    chk("lui Done", 32'(a.Done), 1);
    start_a;
    a.MemReady = 1'b0;
    desc(5, 7'h33, 0, 7'h20, 1, 2, 3, 32'hDEADBEEF, 1);
    send;
    for (int i = 0; i < 3; i++) begin
      chk("stall MemWrite", 32'(a.MemWrite), 1);
      chk("stall MemAddr", 32'(a.MemAddr), 0);
      chk("stall MemData", a.MemData, 32'h403100B3);
      chk("stall InReady", 32'(a.InReady), 0);
      chk("stall Count", 32'(a.Count), 0);
      tick;
    end
    a.MemReady = 1'b1;
    chk("stall 4th MemWrite", 32'(a.MemWrite), 1);
    tick;
    chk("stall retire Count", 32'(a.Count), 1);
    chk("stall retire Done", 32'(a.Done), 1);
    b.Start = 1'b1;
    tick;
    b.Start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b.Rd = 5'(i); b.Imm = 32'(i);
      chk("ovf InReady", 32'(b.InReady), 1);
      b.InValid = 1'b1;
      tick;
      b.InValid = 1'b0;
      chk("ovf MemAddr", 32'(b.MemAddr), 32'(i));
      chk("ovf MemData", b.MemData, (32'(i) << 20) | (32'(i) << 7) | 32'h13);
      tick;
    end
    chk("ovf Error", 32'(b.Error), 1);
    chk("ovf ErrCode", 32'(b.ErrCode), 3);
    chk("ovf Count", 32'(b.Count), 4);
    b.Rd = 5'd4; b.Imm = 4; b.Last = 1'b1; b.InValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("ovf 5th InReady", 32'(b.InReady), 0);
      chk("ovf 5th MemWrite", 32'(b.MemWrite), 0);
      tick;
    end
    b.InValid = 1'b0;
    chk("ovf Count held", 32'(b.Count), 4);
    start_a;
    a.MemReady = 1'b0;
    desc(0, 7'h13, 0, 0, 1, 0, 0, 5, 1);
    send;
    chk("pre-reset MemWrite", 32'(a.MemWrite), 1);
    reset = 1'b1;
    tick;
    reset_vals("mid reset");
    reset = 1'b0;
    a.MemReady = 1'b1;
    start_a;
    desc(0, 7'h13, 0, 0, 2, 0, 0, 7, 1);
    send;
    chk("post-reset MemAddr", 32'(a.MemAddr), 0);
    chk("post-reset MemData", a.MemData, 32'h00700113);
    tick;
    chk("post-reset Count", 32'(a.Count), 1);
    chk("post-reset Done", 32'(a.Done), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
